// File: rtl/cameralink_frame_rx.sv
// Frame-aware CameraLink receiver: arms on a frame gap, tags SOF/EOL through a one-beat
// lookahead hold register, measures geometry and buffers beats in a valid/ready FIFO.
// Optional build macro CAMERALINK_RX_LINE_CHECK_EN adds the sticky line_err output.
module cameralink_frame_rx #(
  parameter int TAPS       = 1,
  parameter int PIXEL_W    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    FVV,
  input  logic                    LVV,
  input  logic                    VCE,
  input  logic [TAPS*PIXEL_W-1:0] pix_data,
  input  logic                    capture_en,
  output logic                    cam_enable,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TAPS*PIXEL_W-1:0] out_data,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic [CNT_W-1:0]        line_beats,
  output logic [CNT_W-1:0]        frame_lines,
  output logic [CNT_W-1:0]        frame_count,
`ifdef CAMERALINK_RX_LINE_CHECK_EN
  output logic                    line_err,
`endif
  output logic                    overflow
);
  localparam int DW = TAPS * PIXEL_W;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT_GAP, ARMED, FRAME} state_t;
  state_t state_q, state_d;

  logic            cam_enable_q, lvv_q, overflow_q;
  logic            hold_valid_q, hold_sof_q, sof_pending_q;
  logic [DW-1:0]   hold_data_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [CNT_W-1:0] beat_cnt_q, line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] line_beats_q, frame_lines_q, frame_count_q;
  logic [DW+1:0]   mem_q [FIFO_DEPTH];
  logic [DW+1:0]   head;
  logic            in_frame, accept, line_end, frame_end, frame_start;
  logic            push, pop, wr_ok;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (capture_en) state_d = WAIT_GAP;
      WAIT_GAP: if (!FVV)       state_d = ARMED;
      ARMED:    if (FVV)        state_d = FRAME;
      FRAME:    if (!FVV)       state_d = capture_en ? ARMED : IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  assign in_frame    = (state_q == FRAME);
  assign accept      = in_frame && FVV && LVV && VCE;
  // lvv_q only tracks lines seen inside FRAME, so a line end covers FVV falling mid-line too
  assign line_end    = in_frame && lvv_q && !(FVV && LVV);
  assign frame_end   = in_frame && !FVV;
  assign frame_start = (state_q == ARMED) && FVV;
  assign push        = hold_valid_q && (accept || line_end);
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid && out_ready;
  assign wr_ok       = push && ((count_q != DEPTH_C) || pop);
  assign line_cnt_d  = (line_end && line_cnt_q != CNT_MAX) ? line_cnt_q + CNT_W'(1) : line_cnt_q;

  always_comb begin
    count_d = count_q;
    if (wr_ok && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!wr_ok && pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem_q[wr_ptr_q] <= {line_end, hold_sof_q, hold_data_q};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cam_enable_q  <= 1'b0;
      lvv_q         <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_sof_q    <= 1'b0;
      hold_data_q   <= '0;
      sof_pending_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      beat_cnt_q    <= '0;
      line_cnt_q    <= '0;
      line_beats_q  <= '0;
      frame_lines_q <= '0;
      frame_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cam_enable_q <= (state_d != IDLE);
      lvv_q        <= in_frame && FVV && LVV;
      if (accept) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= pix_data;
        hold_sof_q   <= sof_pending_q;
      end else if (line_end) begin
        hold_valid_q <= 1'b0;
      end
      if (frame_start)  sof_pending_q <= 1'b1;
      else if (accept)  sof_pending_q <= 1'b0;
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (state_q == IDLE && capture_en) overflow_q <= 1'b0;
      else if (push && !wr_ok)           overflow_q <= 1'b1;
      if (frame_start || line_end)                  beat_cnt_q <= '0;
      else if (accept && beat_cnt_q != CNT_MAX)     beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      if (line_end) line_beats_q <= beat_cnt_q;
      if (frame_start || frame_end) line_cnt_q <= '0;
      else                          line_cnt_q <= line_cnt_d;
      if (frame_end) begin
        frame_lines_q <= line_cnt_d;
        frame_count_q <= frame_count_q + CNT_W'(1);
      end
    end
  end

`ifdef CAMERALINK_RX_LINE_CHECK_EN
  logic [CNT_W-1:0] first_beats_q;
  logic             first_seen_q, line_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      first_beats_q <= '0;
      first_seen_q  <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && capture_en) line_err_q <= 1'b0;
      if (frame_start) begin
        first_seen_q <= 1'b0;
      end else if (line_end) begin
        if (!first_seen_q) begin
          first_seen_q  <= 1'b1;
          first_beats_q <= beat_cnt_q;
        end else if (beat_cnt_q != first_beats_q) begin
          line_err_q <= 1'b1;
        end
      end
    end
  end
  assign line_err = line_err_q;
`endif

  assign head        = mem_q[rd_ptr_q];
  assign out_data    = out_valid ? head[DW-1:0] : '0;
  assign out_sof     = out_valid && head[DW];
  assign out_eol     = out_valid && head[DW+1];
  assign cam_enable  = cam_enable_q;
  assign overflow    = overflow_q;
  assign line_beats  = line_beats_q;
  assign frame_lines = frame_lines_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_cameralink_frame_rx.sv
// Directed-plus-random bench for cameralink_frame_rx; expected beats come from a frame-level
// model (beat list per line with SOF/EOL flags) and are checked as the consumer pops them.
module tb_cameralink_frame_rx;
  localparam int TAPS = 2, PIXEL_W = 8, DEPTH = 16, CNT_W = 16;
  localparam int DW = TAPS * PIXEL_W;

  logic clock = 1'b0;
  logic reset, FVV, LVV, VCE, capture_en, out_ready;
  logic [DW-1:0] pix_data, out_data;
  logic cam_enable, out_valid, out_sof, out_eol, overflow;
  logic [CNT_W-1:0] line_beats, frame_lines, frame_count;
`ifdef CAMERALINK_RX_LINE_CHECK_EN
  logic line_err;
`endif

  always #5 clock = ~clock;

  cameralink_frame_rx #(.TAPS(TAPS), .PIXEL_W(PIXEL_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .FVV(FVV), .LVV(LVV), .VCE(VCE), .pix_data(pix_data),
    .capture_en(capture_en), .cam_enable(cam_enable), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
    .line_beats(line_beats), .frame_lines(frame_lines), .frame_count(frame_count),
`ifdef CAMERALINK_RX_LINE_CHECK_EN
    .line_err(line_err),
`endif
    .overflow(overflow));

  typedef struct packed {logic [DW-1:0] data; logic sof; logic eol;} ent_t;
  ent_t exp_q[$];
  int errors = 0, checks = 0;
  int ready_mode = 0;          // 0: always ready, 1: random, 2: stalled
  bit capturing = 0, sof_next = 0;
  int exp_frames = 0, exp_lines = 0, exp_lb = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: pick out_ready, check any beat popped on the coming edge, then advance.
  task automatic step();
    ent_t e;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    if (out_valid && out_ready) begin
      chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_sof", 32'(out_sof), 32'(e.sof));
        chk("out_eol", 32'(out_eol), 32'(e.eol));
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input bit f, input bit l, input bit v, input logic [DW-1:0] d);
    FVV = f; LVV = l; VCE = v; pix_data = d;
  endtask

  task automatic do_line(input int nb, input bit joint);
    int got;
    bit v;
    ent_t e;
    logic [DW-1:0] d;
    got = 0;
    if (nb == 0) begin
      drive(1, 1, 0, DW'($urandom)); step(); step();
    end
    while (got < nb) begin
      v = ($urandom_range(0, 3) != 0);
      d = DW'($urandom);
      drive(1, 1, v, d);
      if (v) begin
        if (capturing) begin
          e.data = d; e.sof = sof_next; e.eol = (got == nb - 1);
          exp_q.push_back(e);
          sof_next = 0;
        end
        got++;
      end
      step();
    end
    if (joint) begin drive(0, 0, 0, '0); step(); end
    else begin drive(1, 0, 0, '0); step(); step(); end
  endtask

  task automatic do_frame(input int nl, input int bpl, input int lastb, input bit joint, input bit cap);
    capturing = cap; sof_next = cap;
    drive(1, 0, 0, '0); step(); step();
    for (int l = 0; l < nl; l++) do_line((l == nl - 1) ? lastb : bpl, joint && (l == nl - 1));
    if (!joint) begin drive(0, 0, 0, '0); step(); end
    drive(0, 0, 0, '0); step(); step(); step();
    if (cap) begin exp_frames++; exp_lines = nl; exp_lb = lastb; end
    capturing = 0;
  endtask

  task automatic drain();
    if (ready_mode == 2) ready_mode = 0;
    for (int i = 0; i < 400 && (exp_q.size() != 0 || out_valid); i++) step();
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic check_geom();
    chk("line_beats", 32'(line_beats), 32'(exp_lb));
    chk("frame_lines", 32'(frame_lines), 32'(exp_lines));
    chk("frame_count", 32'(frame_count), 32'(exp_frames));
  endtask

  initial begin
    reset = 1; capture_en = 0; out_ready = 1;
    drive(0, 0, 0, '0);
    @(negedge clock);
    step(); step();
    chk("rst_cam_enable", 32'(cam_enable), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    check_geom();
    reset = 0; step();
    chk("idle_cam_enable", 32'(cam_enable), 32'd0);

    // Capture requested while a frame is already in progress: that frame is skipped.
    drive(1, 0, 0, '0); step();
    capture_en = 1; step();
    chk("wait_gap_cam_enable", 32'(cam_enable), 32'd1);
    do_line(4, 0); do_line(3, 0);
    drive(0, 0, 0, '0); step(); step();
    chk("midframe_ignored", 32'(out_valid), 32'd0);
    chk("midframe_no_count", 32'(frame_count), 32'd0);
    do_frame(2, 4, 4, 0, 1);
    drain(); check_geom();

    // Consumer stalled across a 3x8 frame: first DEPTH beats survive, the rest drop.
    ready_mode = 2;
    do_frame(3, 8, 8, 0, 1);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("overflow_set", 32'(overflow), 32'd1);
    step(); step();
    chk("stall_head_steady", 32'(out_data), 32'(exp_q[0].data));
    drain(); check_geom();

    // capture_en dropped mid-frame: frame completes, then cam_enable falls.
    ready_mode = 0; capturing = 1; sof_next = 1;
    drive(1, 0, 0, '0); step(); step();
    do_line(3, 0);
    capture_en = 0;
    do_line(3, 0);
    drive(0, 0, 0, '0);
    chk("cam_before_fvv_fall", 32'(cam_enable), 32'd1);
    step();
    chk("cam_after_fvv_fall", 32'(cam_enable), 32'd0);
    exp_frames++; exp_lines = 2; exp_lb = 3; capturing = 0;
    step(); step();
    drain(); check_geom();
    chk("overflow_sticky", 32'(overflow), 32'd1);
    capture_en = 1; step();
    chk("overflow_cleared", 32'(overflow), 32'd0);
    chk("cam_rearmed", 32'(cam_enable), 32'd1);

    // Reset in line 2 of a frame: nothing from that frame, capture resumes on the next.
    step();
    capturing = 1; sof_next = 1;
    drive(1, 0, 0, '0); step(); step();
    do_line(4, 0);
    drive(1, 1, 1, DW'($urandom)); step();
    drive(1, 1, 1, DW'($urandom)); reset = 1; step();
    chk("reset_cam_enable", 32'(cam_enable), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    step(); reset = 0;
    exp_q.delete(); capturing = 0; sof_next = 0;
    exp_frames = 0; exp_lines = 0; exp_lb = 0;
    do_line(4, 0); do_line(4, 0);
    drive(0, 0, 0, '0); step(); step(); step();
    chk("post_reset_empty", 32'(out_valid), 32'd0);
    chk("post_reset_count", 32'(frame_count), 32'd0);
    do_frame(2, 3, 3, 0, 1);
    drain(); check_geom();

`ifdef CAMERALINK_RX_LINE_CHECK_EN
    do_frame(3, 4, 4, 0, 1);
    drain();
    chk("line_err_uniform", 32'(line_err), 32'd0);
    do_frame(3, 4, 3, 0, 1);
    drain();
    chk("line_err_short", 32'(line_err), 32'd1);
    check_geom();
`endif

    // Zero-beat last line, then FVV and LVV falling together.
    do_frame(3, 3, 0, 0, 1);
    drain(); check_geom();
    do_frame(2, 3, 3, 1, 1);
    drain(); check_geom();

    ready_mode = 1;
    for (int f = 0; f < 6; f++) begin
      do_frame($urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(0, 4),
               1'($urandom_range(0, 1)), 1);
      drain(); check_geom();
    end
    chk("no_overflow_random", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
